// File: rtl/d2l_pkg.sv
// Shared definitions for the D2L receive path.
//   D2L_LANE_W  : default width of each data lane
//   rx_state_e  : receiver FSM state names
//   ST_*        : the same states as plain logic constants for the state register
//   word_w()    : width of one reassembled word for a given lane width and beat count
package d2l_pkg;

  localparam int D2L_LANE_W = 4;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2
  } rx_state_e;

  localparam logic [1:0] ST_WAIT_IDLE = WAIT_IDLE;
  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_RECV      = RECV;

  // Two lanes deliver lane_w bits each per beat.
  function automatic int word_w(input int lane_w, input int beats);
    return 2 * lane_w * beats;
  endfunction

endpackage

// File: rtl/d2l_sync_fifo.sv
// First-word-fall-through FIFO with registered head outputs.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : push request; dropped when full unless a pop happens in the same cycle
//   wr_data   : word to push
//   rd_en     : pop request; ignored when empty
//   rd_data   : registered head entry (zero when empty)
//   rd_valid  : registered, high while the FIFO holds at least one entry
//   full      : registered, FIFO holds DEPTH entries
//   empty     : registered, FIFO holds no entries
//   level     : registered occupancy
module d2l_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] LVL_ZERO  = (AW+1)'(0);
  localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic [AW:0]      wptr_next_s;
  logic [AW:0]      rptr_next_s;
  logic [AW:0]      level_next_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic             head_is_new_s;
  logic [WIDTH-1:0] head_next_s;

  // A pop frees a slot before the push is judged, so full+push+pop is accepted.
  assign rd_ok_s = rd_en & ~empty;
  assign wr_ok_s = wr_en & (~full | rd_ok_s);

  // Next pointers, occupancy and head word.
  always_comb begin
    wptr_next_s   = wptr_r;
    rptr_next_s   = rptr_r;
    head_next_s   = '0;
    head_is_new_s = 1'b0;
    if (wr_ok_s) begin
      wptr_next_s = wptr_r + PTR_ONE;
    end else begin
      wptr_next_s = wptr_r;
    end
    if (rd_ok_s) begin
      rptr_next_s = rptr_r + PTR_ONE;
    end else begin
      rptr_next_s = rptr_r;
    end
    level_next_s = wptr_next_s - rptr_next_s;
    // The pushed word becomes the head only if nothing older remains after the pop.
    head_is_new_s = wr_ok_s & ((level == LVL_ZERO) | ((level == PTR_ONE) & rd_ok_s));
    if (level_next_s == LVL_ZERO) begin
      head_next_s = '0;
    end else if (head_is_new_s) begin
      head_next_s = wr_data;
    end else begin
      head_next_s = mem_r[rptr_next_s[AW-1:0]];
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointers, status flags and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      wptr_r   <= wptr_next_s;
      rptr_r   <= rptr_next_s;
      level    <= level_next_s;
      rd_data  <= head_next_s;
      rd_valid <= (level_next_s != LVL_ZERO);
      full     <= (level_next_s == LVL_FULL);
      empty    <= (level_next_s == LVL_ZERO);
    end
  end

endmodule

// File: rtl/d2l_rx_deserializer.sv
// D2L dual-lane link receiver: synchronizes the master's sclk/cs_n/lanes, reassembles
// BEATS beats into one word and queues words for a valid/ready consumer.
//   clk, rst   : system clock (>= 4x sclk), synchronous active-high reset
//   sclk, cs_n : link clock and active-low frame select, asynchronous to clk
//   dl0, dl1   : lane data; dl0 is the low half of each beat
//   m_data     : received word, beat 0 in the LSBs
//   m_valid    : m_data holds a word; m_ready accepts it
//   frame_err  : one-cycle pulse when a frame ends mid-word
//   overflow   : sticky, set when a completed word is dropped; ovf_clr clears (set wins)
//   busy       : high while receiving a frame
//   fifo_level : output FIFO occupancy
module d2l_rx_deserializer
  import d2l_pkg::*;
#(
  parameter int LANE_W      = D2L_LANE_W,
  parameter int BEATS       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sclk,
  input  logic                              cs_n,
  input  logic [LANE_W-1:0]                 dl0,
  input  logic [LANE_W-1:0]                 dl1,
  output logic [word_w(LANE_W, BEATS)-1:0]  m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              frame_err,
  output logic                              overflow,
  input  logic                              ovf_clr,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int WORD_W = word_w(LANE_W, BEATS);
  localparam int BEAT_W = 2 * LANE_W;
  localparam int IN_W   = BEAT_W + 2;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  // Bundle {sclk, cs_n, dl1, dl0} so every signal sees the same synchronizer depth.
  logic [IN_W-1:0]   sync_r [SYNC_STAGES];
  logic              sclk_d_r;
  logic              sync_sclk_s;
  logic              sync_cs_n_s;
  logic [BEAT_W-1:0] sync_beat_s;
  logic              rise_s;

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [WORD_W-1:0] shift_r;
  logic [WORD_W-1:0] shift_next_s;
  logic [WORD_W-1:0] word_s;
  logic [WORD_W-1:0] word_r;
  logic              push_r;
  logic              push_next_s;
  logic              err_next_s;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              pop_s;
  logic              drop_s;

  assign sync_sclk_s = sync_r[SYNC_STAGES-1][IN_W-1];
  assign sync_cs_n_s = sync_r[SYNC_STAGES-1][IN_W-2];
  assign sync_beat_s = sync_r[SYNC_STAGES-1][BEAT_W-1:0];
  assign rise_s      = sync_sclk_s & ~sclk_d_r;

  // Input synchronizer chain plus the extra sclk flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      sclk_d_r <= 1'b0;
    end else begin
      sync_r[0] <= {sclk, cs_n, dl1, dl0};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      sclk_d_r <= sync_sclk_s;
    end
  end

  // Receiver FSM: next state, beat slot insertion, push and frame-error decisions.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = beat_cnt_r;
    shift_next_s = shift_r;
    push_next_s  = 1'b0;
    err_next_s   = 1'b0;
    word_s       = shift_r;
    word_s[int'(beat_cnt_r) * BEAT_W +: BEAT_W] = sync_beat_s;
    case (state_r)
      ST_WAIT_IDLE: begin
        cnt_next_s = CNT_ZERO;
        if (sync_cs_n_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_IDLE;
        end
      end
      ST_IDLE: begin
        cnt_next_s = CNT_ZERO;
        if (!sync_cs_n_s) begin
          state_next_s = ST_RECV;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        // A beat arriving together with cs_n high is captured before the frame closes.
        if (rise_s) begin
          shift_next_s = word_s;
          if (beat_cnt_r == LAST_BEAT) begin
            push_next_s = 1'b1;
            cnt_next_s  = CNT_ZERO;
          end else begin
            cnt_next_s  = beat_cnt_r + CNT_ONE;
          end
        end else begin
          cnt_next_s = beat_cnt_r;
        end
        if (sync_cs_n_s) begin
          err_next_s   = (cnt_next_s != CNT_ZERO);
          cnt_next_s   = CNT_ZERO;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RECV;
        end
      end
      default: begin
        state_next_s = ST_WAIT_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM state, beat counter, shift register and the registered push/error/busy strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_WAIT_IDLE;
      beat_cnt_r <= '0;
      shift_r    <= '0;
      word_r     <= '0;
      push_r     <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      beat_cnt_r <= cnt_next_s;
      shift_r    <= shift_next_s;
      if (push_next_s) begin
        word_r <= word_s;
      end
      push_r     <= push_next_s;
      frame_err  <= err_next_s;
      busy       <= (state_next_s == ST_RECV);
    end
  end

  assign pop_s  = m_ready & ~fifo_empty_s;
  assign drop_s = push_r & fifo_full_s & ~pop_s;

  // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  d2l_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push_r),
    .wr_data  (word_r),
    .rd_en    (m_ready),
    .rd_data  (m_data),
    .rd_valid (m_valid),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .level    (fifo_level)
  );

endmodule
